// File: rtl/panda_top_tb_harness_pkg.sv
// Shared constants for the PCAP core: register map, IRQ flag bits, FSM states,
// sample word width and the IRQ_STATUS word packing.
package panda_pcap_pkg;

  localparam int SMPL_W = 32;

  localparam logic [3:0] ADDR_ARM          = 4'd0;
  localparam logic [3:0] ADDR_DISARM       = 4'd1;
  localparam logic [3:0] ADDR_TRIG_SEL     = 4'd2;
  localparam logic [3:0] ADDR_FRAMING_MASK = 4'd3;
  localparam logic [3:0] ADDR_MAX_SAMPLES  = 4'd4;
  localparam logic [3:0] ADDR_IRQ_STATUS   = 4'd5;
  localparam logic [3:0] ADDR_SMPL_COUNT   = 4'd6;

  localparam int FLAG_DONE   = 0;
  localparam int FLAG_DISARM = 1;
  localparam int FLAG_OVF    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DRAIN = 2'd2
  } pcap_state_t;

  function automatic logic [31:0] irq_status_word(logic [15:0] cnt, logic [7:0] flags);
    return {cnt, 8'h00, flags};
  endfunction

endpackage

// File: rtl/panda_top_tb_harness_if.sv
// Register bus plus DMA write stream of the PCAP core.
// master = software/DMA side, slave = PCAP core.
interface panda_top_tb_harness_if;
  import panda_pcap_pkg::*;

  logic              mem_cs_i;
  logic              mem_wstb_i;
  logic [3:0]        mem_addr_i;
  logic [31:0]       mem_dat_i;
  logic [31:0]       mem_dat_o;
  logic [SMPL_W-1:0] dma_data_o;
  logic              dma_valid_o;
  logic              dma_ready_i;

  modport master (
    output mem_cs_i, mem_wstb_i, mem_addr_i, mem_dat_i, dma_ready_i,
    input  mem_dat_o, dma_data_o, dma_valid_o
  );

  modport slave (
    input  mem_cs_i, mem_wstb_i, mem_addr_i, mem_dat_i, dma_ready_i,
    output mem_dat_o, dma_data_o, dma_valid_o
  );
endinterface

// File: rtl/panda_top_tb_harness_fifo.sv
// Synchronous first-word-fall-through sample FIFO; DEPTH must be a power of 2.
// Output data is forced to 0 while empty.
module pcap_sample_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/panda_top_tb_harness.sv
// PCAP core: TTL sync/edge detect, capture FSM, timestamp/sample counters, reg file.
// Optional trigger framing gate enabled by defining PCAP_FRAMING_EN.
//   state    | meaning
//   ST_IDLE  | waiting for ARM; FIFO empty
//   ST_ARMED | timestamp running, triggers captured into FIFO
//   ST_DRAIN | capture stopped, waiting for DMA to empty the FIFO
module panda_top_tb_harness
  import panda_pcap_pkg::*;
#(
  parameter int FIFO_DEPTH = 32,
  parameter int TS_WIDTH   = SMPL_W - 6
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [5:0] ttlin_i,
  output logic       irq_o,
  panda_top_tb_harness_if.slave bus
);

  pcap_state_t       state, state_nxt;
  logic [2:0]        trig_sel;
  logic [5:0]        framing_mask;
  logic [15:0]       max_samples;
  logic [15:0]       smpl_count, cnt_inc;
  logic [7:0]        irq_flags;
  logic [TS_WIDTH-1:0] ts;
  logic [31:0]       rd_mux, rd_data;
  logic [5:0]        ttl_meta, ttl_sync, ttl_prev, ttl_cap;
  logic [7:0]        rise_ext;
  logic              trig_now, trig_q;
  logic              wr_en, rd_en, arm_wr, disarm_wr, rd_status;
  logic              arm_evt, cap_push, ovf_evt, done_evt, disarm_evt, irq_set, ts_run;
  logic              fifo_full, fifo_empty;
  logic              unused_dat;

  assign wr_en      = bus.mem_cs_i & bus.mem_wstb_i;
  assign rd_en      = bus.mem_cs_i & ~bus.mem_wstb_i;
  assign arm_wr     = wr_en && (bus.mem_addr_i == ADDR_ARM);
  assign disarm_wr  = wr_en && (bus.mem_addr_i == ADDR_DISARM);
  assign rd_status  = rd_en && (bus.mem_addr_i == ADDR_IRQ_STATUS);
  assign unused_dat = ^bus.mem_dat_i[31:16];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      trig_sel     <= '0;
      framing_mask <= '0;
      max_samples  <= '0;
    end else if (wr_en) begin
      case (bus.mem_addr_i)
        ADDR_TRIG_SEL:     trig_sel <= bus.mem_dat_i[2:0];
`ifdef PCAP_FRAMING_EN
        ADDR_FRAMING_MASK: framing_mask <= bus.mem_dat_i[5:0];
`else
        ADDR_FRAMING_MASK: framing_mask <= '0;
`endif
        ADDR_MAX_SAMPLES:  max_samples <= bus.mem_dat_i[15:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.mem_addr_i)
      ADDR_TRIG_SEL:     rd_mux = {29'd0, trig_sel};
      ADDR_FRAMING_MASK: rd_mux = {26'd0, framing_mask};
      ADDR_MAX_SAMPLES:  rd_mux = {16'd0, max_samples};
      ADDR_IRQ_STATUS:   rd_mux = irq_status_word(smpl_count, irq_flags);
      ADDR_SMPL_COUNT:   rd_mux = {16'd0, smpl_count};
      default:           rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) rd_data <= '0;
    else         rd_data <= rd_en ? rd_mux : '0;
  end

  // Trigger is registered once more so the FIFO write lands 3 cycles after sampling.
  assign rise_ext = {2'b00, ttl_sync & ~ttl_prev};
  assign trig_now = rise_ext[trig_sel] && ((ttl_sync & framing_mask) == framing_mask);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ttl_meta <= '0;
      ttl_sync <= '0;
      ttl_prev <= '0;
      ttl_cap  <= '0;
      trig_q   <= 1'b0;
    end else begin
      ttl_meta <= ttlin_i;
      ttl_sync <= ttl_meta;
      ttl_prev <= ttl_sync;
      ttl_cap  <= ttl_sync;
      trig_q   <= trig_now;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (arm_wr) state_nxt = ST_ARMED;
      ST_ARMED: if (ovf_evt || done_evt || disarm_wr) state_nxt = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign cnt_inc = smpl_count + 16'd1;

  always_comb begin
    arm_evt    = 1'b0;
    cap_push   = 1'b0;
    ovf_evt    = 1'b0;
    done_evt   = 1'b0;
    disarm_evt = 1'b0;
    irq_set    = 1'b0;
    ts_run     = 1'b0;
    case (state)
      ST_IDLE:  arm_evt = arm_wr;
      ST_ARMED: begin
        ts_run     = 1'b1;
        cap_push   = trig_q & ~fifo_full;
        ovf_evt    = trig_q & fifo_full;
        done_evt   = trig_q & ~fifo_full & (max_samples != '0) & (cnt_inc == max_samples);
        disarm_evt = disarm_wr;
      end
      ST_DRAIN: irq_set = fifo_empty;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      smpl_count <= '0;
      irq_flags  <= '0;
      ts         <= '0;
      irq_o      <= 1'b0;
    end else begin
      if (arm_evt) begin
        smpl_count <= '0;
        irq_flags  <= '0;
        ts         <= '0;
      end else begin
        if (ts_run)     ts <= ts + TS_WIDTH'(1);
        if (cap_push)   smpl_count <= cnt_inc;
        if (done_evt)   irq_flags[FLAG_DONE] <= 1'b1;
        if (disarm_evt) irq_flags[FLAG_DISARM] <= 1'b1;
        if (ovf_evt)    irq_flags[FLAG_OVF] <= 1'b1;
      end
      // Set on drain completion wins over a coincident status read.
      if (arm_evt)        irq_o <= 1'b0;
      else if (irq_set)   irq_o <= 1'b1;
      else if (rd_status) irq_o <= 1'b0;
    end
  end

  pcap_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SMPL_W)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .push      (cap_push),
    .push_data ({ts, ttl_cap}),
    .pop       (bus.dma_ready_i),
    .pop_data  (bus.dma_data_o),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.dma_valid_o = ~fifo_empty;
  assign bus.mem_dat_o   = rd_data;

endmodule

// File: tb/tb_panda_top_tb_harness.sv
// Randomized bench for the PCAP core against a sample-list reference model.
module tb_panda_top_tb_harness;
  import panda_pcap_pkg::*;

  typedef struct {
    int         cyc;
    logic [5:0] ttl;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic [5:0] ttlin_i = '0;
  logic       irq_o;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_bad = 0;

  exp_t        exp_q[$];
  logic [31:0] got_q[$];
  int          m_count;
  logic [7:0]  m_flags;
  bit          m_armed;
  int          m_max;
  logic [5:0]  m_mask;

  panda_top_tb_harness_if bus();

  panda_top_tb_harness dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .ttlin_i (ttlin_i),
    .irq_o   (irq_o),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Words handed to DMA: valid & ready are stable at the falling edge.
  always @(negedge clk_i)
    if (!reset_i && bus.dma_valid_o && bus.dma_ready_i) got_q.push_back(bus.dma_data_o);

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic reg_wr(logic [3:0] addr, logic [31:0] data);
    bus.mem_cs_i   = 1'b1;
    bus.mem_wstb_i = 1'b1;
    bus.mem_addr_i = addr;
    bus.mem_dat_i  = data;
    tick();
    bus.mem_cs_i   = 1'b0;
    bus.mem_wstb_i = 1'b0;
  endtask

  task automatic reg_rd(logic [3:0] addr, output logic [31:0] data);
    bus.mem_cs_i   = 1'b1;
    bus.mem_wstb_i = 1'b0;
    bus.mem_addr_i = addr;
    tick();
    bus.mem_cs_i   = 1'b0;
    data = bus.mem_dat_o;
  endtask

  task automatic arm_op();
    reg_wr(ADDR_ARM, 32'd0);
    if (!m_armed) begin
      m_armed = 1'b1;
      m_count = 0;
      m_flags = '0;
      exp_q.delete();
      got_q.delete();
    end
  endtask

  task automatic disarm_op();
    reg_wr(ADDR_DISARM, 32'd0);
    if (m_armed) begin
      m_flags[1] = 1'b1;
      m_armed    = 1'b0;
    end
  endtask

  task automatic set_max(int v);
    reg_wr(ADDR_MAX_SAMPLES, 32'(v));
    m_max = v;
  endtask

  task automatic model_sample(logic [5:0] hi);
    if (m_armed && ((hi & m_mask) == m_mask)) begin
      if (exp_q.size() - got_q.size() >= 32) begin
        m_flags[2] = 1'b1;
        m_armed    = 1'b0;
      end else begin
        exp_q.push_back('{cyc, hi});
        m_count++;
        if (m_max != 0 && m_count == m_max) begin
          m_flags[0] = 1'b1;
          m_armed    = 1'b0;
        end
      end
    end
  endtask

  // One low-then-high pulse on bit sel; fmask/fval pin other bits.
  task automatic pulse(int sel, logic [5:0] fmask, logic [5:0] fval);
    logic [5:0] lo, hi, one;
    one = 6'd1 << sel;
    lo  = ((6'($urandom) & ~fmask) | fval) & ~one;
    hi  = ((6'($urandom) & ~fmask) | fval) | one;
    ttlin_i = lo;
    repeat (4) tick();
    ttlin_i = hi;
    model_sample(hi);
    repeat (4) tick();
  endtask

  // The rising edge reaches the FIFO write on the same edge that samples DISARM.
  task automatic pulse_disarm(int sel);
    bit was_armed;
    logic [5:0] one;
    was_armed = m_armed;
    one = 6'd1 << sel;
    ttlin_i = 6'($urandom) & ~one;
    repeat (4) tick();
    ttlin_i = ttlin_i | one;
    model_sample(ttlin_i);
    repeat (3) tick();
    reg_wr(ADDR_DISARM, 32'd0);
    if (was_armed) begin
      m_flags[1] = 1'b1;
      m_armed    = 1'b0;
    end
    repeat (3) tick();
  endtask

  task automatic finish_round(string tag, output logic [31:0] st);
    int n;
    logic [25:0] d;
    if (m_armed) disarm_op();
    n = 0;
    while (!irq_o && n < 600) begin
      tick();
      n++;
    end
    check_eq({tag, "_irq"}, {31'd0, irq_o}, 32'd1);
    check_eq({tag, "_nwords"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      d = got_q[i][31:6] - got_q[0][31:6];
      check_eq({tag, "_ttl"}, {26'd0, got_q[i][5:0]}, {26'd0, exp_q[i].ttl});
      check_eq({tag, "_tsdelta"}, {6'd0, d}, 32'(exp_q[i].cyc - exp_q[0].cyc));
    end
    reg_rd(ADDR_IRQ_STATUS, st);
    check_eq({tag, "_status"}, st, {m_count[15:0], 8'h00, m_flags});
    tick();
    check_eq({tag, "_irq_clr"}, {31'd0, irq_o}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd, st;
    int sel;
    bus.mem_cs_i    = 1'b0;
    bus.mem_wstb_i  = 1'b0;
    bus.mem_addr_i  = '0;
    bus.mem_dat_i   = '0;
    bus.dma_ready_i = 1'b0;
    m_count = 0; m_flags = '0; m_armed = 1'b0; m_max = 0; m_mask = '0;
    repeat (3) tick();
    reset_i = 1'b0;
    tick();

    check_eq("rst_irq", {31'd0, irq_o}, 32'd0);
    check_eq("rst_valid", {31'd0, bus.dma_valid_o}, 32'd0);
    check_eq("rst_data", bus.dma_data_o, 32'd0);
    reg_rd(ADDR_IRQ_STATUS, rd);
    check_eq("rst_status", rd, 32'd0);
    reg_rd(ADDR_SMPL_COUNT, rd);
    check_eq("rst_count", rd, 32'd0);
    bus.dma_ready_i = 1'b1;

    // MAX=4 completion; extra pulses after done are not captured.
    reg_wr(ADDR_TRIG_SEL, 32'd0);
    set_max(4);
    arm_op();
    repeat (6) pulse(0, 6'd0, 6'd0);
    finish_round("max4", st);
    check_eq("max4_const", st, 32'h0004_0001);

    // Unlimited, user disarm after three pulses.
    sel = $urandom_range(0, 5);
    reg_wr(ADDR_TRIG_SEL, 32'(sel));
    set_max(0);
    arm_op();
    repeat (3) pulse(sel, 6'd0, 6'd0);
    finish_round("disarm", st);
    check_eq("disarm_const", st, 32'h0003_0002);

    // Overflow with DMA stalled.
    reg_wr(ADDR_TRIG_SEL, 32'd0);
    bus.dma_ready_i = 1'b0;
    arm_op();
    repeat (33) pulse(0, 6'd0, 6'd0);
    reg_rd(ADDR_SMPL_COUNT, rd);
    check_eq("ovf_count", rd, 32'd32);
    check_eq("ovf_valid", {31'd0, bus.dma_valid_o}, 32'd1);
    check_eq("ovf_irq_held", {31'd0, irq_o}, 32'd0);
    bus.dma_ready_i = 1'b1;
    finish_round("ovf", st);
    check_eq("ovf_const", st, 32'h0020_0004);

    // Framing gate on ttl[1].
    reg_wr(ADDR_FRAMING_MASK, 32'h02);
    reg_rd(ADDR_FRAMING_MASK, rd);
`ifdef PCAP_FRAMING_EN
    m_mask = 6'h02;
    check_eq("frm_readback", rd, 32'h02);
`else
    check_eq("frm_readback", rd, 32'h00);
`endif
    arm_op();
    repeat (2) pulse(0, 6'h02, 6'h00);
    repeat (2) pulse(0, 6'h02, 6'h02);
    reg_rd(ADDR_SMPL_COUNT, rd);
    check_eq("frm_count", rd, 32'(m_count));
    finish_round("frm", st);
    reg_wr(ADDR_FRAMING_MASK, 32'h00);
    m_mask = '0;

    // ARM while ARMED must not clear the count.
    arm_op();
    repeat (2) pulse(0, 6'd0, 6'd0);
    arm_op();
    pulse(0, 6'd0, 6'd0);
    reg_rd(ADDR_SMPL_COUNT, rd);
    check_eq("rearm_count", rd, 32'(m_count));
    finish_round("rearm", st);

    // TRIG_SEL values 6/7 never trigger.
    reg_wr(ADDR_TRIG_SEL, 32'(6 + $urandom_range(0, 1)));
    arm_op();
    repeat (3) begin
      ttlin_i = 6'h00;
      repeat (4) tick();
      ttlin_i = 6'h3f;
      repeat (4) tick();
    end
    reg_rd(ADDR_SMPL_COUNT, rd);
    check_eq("sel67_count", rd, 32'd0);
    finish_round("sel67", st);

    // Trigger coincident with DISARM, then with completion as well.
    reg_wr(ADDR_TRIG_SEL, 32'd0);
    arm_op();
    pulse(0, 6'd0, 6'd0);
    pulse_disarm(0);
    finish_round("trgdis", st);
    set_max(1);
    arm_op();
    pulse_disarm(0);
    finish_round("donedis", st);
    check_eq("donedis_const", st, 32'h0001_0003);

    // Randomized rounds.
    for (int r = 0; r < 6; r++) begin
      sel = $urandom_range(0, 5);
      reg_wr(ADDR_TRIG_SEL, 32'(sel));
      set_max($urandom_range(0, 5));
      arm_op();
      repeat ($urandom_range(1, 7)) pulse(sel, 6'd0, 6'd0);
      finish_round("rand", st);
    end

    // Reset mid-capture.
    bus.dma_ready_i = 1'b0;
    reg_wr(ADDR_TRIG_SEL, 32'd0);
    set_max(0);
    arm_op();
    repeat (3) pulse(0, 6'd0, 6'd0);
    reset_i = 1'b1;
    repeat (2) tick();
    reset_i = 1'b0;
    m_armed = 1'b0; m_count = 0; m_flags = '0; m_max = 0;
    exp_q.delete();
    got_q.delete();
    tick();
    check_eq("mrst_irq", {31'd0, irq_o}, 32'd0);
    check_eq("mrst_valid", {31'd0, bus.dma_valid_o}, 32'd0);
    reg_rd(ADDR_SMPL_COUNT, rd);
    check_eq("mrst_count", rd, 32'd0);
    reg_rd(ADDR_IRQ_STATUS, rd);
    check_eq("mrst_status", rd, 32'd0);
    bus.dma_ready_i = 1'b1;
    repeat (5) tick();
    check_eq("mrst_nwords", got_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
